// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter and fetch-sequencing stage for one core of the single-cycle
//   manycore MIPS. Presents a word-aligned fetch address to the core's
//   instruction ROM, takes the returned instruction word and chooses the next
//   PC (sequential, beq, j). A HALT opcode freezes the core until reset. Retired
//   instructions are counted, saturating at all-ones.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          synchronous, active-high reset (highest priority)
//   start_i          one-cycle pulse releasing the core from IDLE
//   stall_i          holds PC, count and state while in RUN
//   instr_i[31:0]    instruction word returned by the ROM for address pc_o
//   branch_taken_i   beq condition for the current instruction
//   pc_o[31:0]       fetch address to the ROM
//   pc_plus4_o[31:0] pc_o + 4, combinational
//   running_o        1 while in RUN
//   halted_o         1 while in HALTED
//   instr_count_o    instructions retired since reset
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int          CORE_ID     = 0,
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic [31:0] instr_i,
   input  logic        branch_taken_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        running_o,
   output logic        halted_o,
   output logic [31:0] instr_count_o
);

   localparam logic [5:0] OP_J   = 6'd2;
   localparam logic [5:0] OP_BEQ = 6'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] count_q, count_d;
   logic        running_q, running_d;
   logic        halted_q, halted_d;
   logic        retire_s;
   logic [5:0]  opcode_s;
   logic [31:0] jump_target_s;
   logic [31:0] branch_target_s;

   // Saturating increment so the retire counter never wraps back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      if (value == 32'hFFFF_FFFF) begin
         sat_inc = value;
      end else begin
         sat_inc = value + 32'd1;
      end
   endfunction

   assign opcode_s        = instr_i[31:26];
   assign pc_plus4_o      = pc_q + 32'd4;
   assign jump_target_s   = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
   // Word offset is sign-extended and scaled by 4; the add wraps modulo 2^32.
   assign branch_target_s = pc_plus4_o + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

   // Next-state, next-PC and retire-count selection.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      count_d   = count_q;
      retire_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!stall_i) begin
               retire_s = 1'b1;
               count_d  = sat_inc(count_q);
               if (opcode_s == HALT_OPCODE) begin
                  state_d = ST_HALTED;
               end else if (opcode_s == OP_J) begin
                  pc_d = jump_target_s;
               end else if ((opcode_s == OP_BEQ) && branch_taken_i) begin
                  pc_d = branch_target_s;
               end else begin
                  pc_d = pc_plus4_o;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = RESET_PC;
         end
      endcase
      running_d = (state_d == ST_RUN);
      halted_d  = (state_d == ST_HALTED);
   end

   // State, PC, counter and status flags; reset returns everything to IDLE.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         count_q   <= 32'd0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         running_q <= running_d;
         halted_q  <= halted_d;
      end
   end

   assign pc_o          = pc_q;
   assign instr_count_o = count_q;
   assign running_o     = running_q;
   assign halted_o      = halted_q;

`ifndef SYNTHESIS
   // Simulation-only retire trace.
   always @(posedge clk_i) begin
      if (!reset_i && retire_s) begin
         $display("[%0t] core %0d retire pc=%h instr=%h", $time, CORE_ID, pc_q, instr_i);
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic        stall_i;
   logic [31:0] instr_i;
   logic        branch_taken_i;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        running_o;
   logic        halted_o;
   logic [31:0] instr_count_o;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] NOP      = 32'h0000_F020;           // add $30,$0,$0
   localparam logic [31:0] HALT     = {6'd63, 26'd0};
   localparam logic [31:0] BEQ_M4   = {6'd4, 5'd6, 5'd0, 16'hFFFC};
   localparam logic [31:0] BEQ_M2   = {6'd4, 5'd0, 5'd0, 16'hFFFE};
   localparam logic [31:0] J_10     = {6'd2, 26'h10};
   localparam logic [31:0] RTYPE_BT = 32'h0000_0010;

   pc_fetch_unit #(.CORE_ID(0), .RESET_PC(32'd0), .HALT_OPCODE(6'd63)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stall_i(stall_i),
      .instr_i(instr_i), .branch_taken_i(branch_taken_i), .pc_o(pc_o),
      .pc_plus4_o(pc_plus4_o), .running_o(running_o), .halted_o(halted_o),
      .instr_count_o(instr_count_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] jmp(input logic [31:0] addr);
      jmp = {6'd2, addr[27:2]};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic go(input logic [31:0] ins, input logic bt);
      instr_i        = ins;
      branch_taken_i = bt;
      tick();
      branch_taken_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
      instr_i = jmp(32'h100);
      tick();
      reset_i = 1'b0;
      repeat (10) tick();
      checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
      checks++; if (running_o !== 1'b0 || halted_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", running_o, halted_o); end
      checks++; if (instr_count_o !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count_o); end
      checks++; if (pc_plus4_o !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4_o, 32'h4); end
   endtask

   task automatic test_sequential();
      start_i = 1'b1; instr_i = NOP;
      tick();
      start_i = 1'b0;
      checks++; if (running_o !== 1'b1 || pc_o !== 32'h0 || instr_count_o !== 32'd0) begin
         failures++; $display("FAIL start run=%b pc=%h cnt=%0d exp run=1 pc=0 cnt=0", running_o, pc_o, instr_count_o);
      end
      for (int i = 1; i <= 3; i++) begin
         go(NOP, 1'b0);
         checks++; if (pc_o !== 32'(4 * i) || instr_count_o !== 32'(i)) begin
            failures++; $display("FAIL seq_%0d pc=%h cnt=%0d exp pc=%h cnt=%0d", i, pc_o, instr_count_o, 32'(4 * i), i);
         end
      end
   endtask

   task automatic test_branch();
      go(jmp(32'h48), 1'b0);
      checks++; if (pc_o !== 32'h48 || instr_count_o !== 32'd4) begin failures++; $display("FAIL br_setup pc=%h cnt=%0d exp pc=48 cnt=4", pc_o, instr_count_o); end
      go(BEQ_M4, 1'b1);
      checks++; if (pc_o !== 32'h3C || instr_count_o !== 32'd5) begin failures++; $display("FAIL beq_taken pc=%h cnt=%0d exp pc=3c cnt=5", pc_o, instr_count_o); end
      go(jmp(32'h48), 1'b0);
      go(BEQ_M4, 1'b0);
      checks++; if (pc_o !== 32'h4C || instr_count_o !== 32'd7) begin failures++; $display("FAIL beq_not_taken pc=%h cnt=%0d exp pc=4c cnt=7", pc_o, instr_count_o); end
   endtask

   task automatic test_jump();
      go(jmp(32'h20), 1'b0);
      checks++; if (pc_o !== 32'h20) begin failures++; $display("FAIL j_setup pc=%h exp=20", pc_o); end
      go(J_10, 1'b0);
      checks++; if (pc_o !== 32'h40 || instr_count_o !== 32'd9) begin failures++; $display("FAIL jump pc=%h cnt=%0d exp pc=40 cnt=9", pc_o, instr_count_o); end
      go(RTYPE_BT, 1'b1);
      checks++; if (pc_o !== 32'h44 || instr_count_o !== 32'd10) begin failures++; $display("FAIL bt_ignored pc=%h cnt=%0d exp pc=44 cnt=10", pc_o, instr_count_o); end
   endtask

   task automatic test_stall();
      go(jmp(32'h14), 1'b0);
      stall_i = 1'b1; instr_i = NOP;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc_o !== 32'h14 || instr_count_o !== 32'd11) begin
            failures++; $display("FAIL stall_%0d pc=%h cnt=%0d exp pc=14 cnt=11", i, pc_o, instr_count_o);
         end
      end
      instr_i = HALT;
      tick();
      checks++; if (running_o !== 1'b1 || halted_o !== 1'b0 || pc_o !== 32'h14 || instr_count_o !== 32'd11) begin
         failures++; $display("FAIL halt_under_stall run=%b halt=%b pc=%h cnt=%0d exp 1 0 14 11", running_o, halted_o, pc_o, instr_count_o);
      end
      stall_i = 1'b0; start_i = 1'b1;
      go(NOP, 1'b0);
      start_i = 1'b0;
      checks++; if (pc_o !== 32'h18 || instr_count_o !== 32'd12 || running_o !== 1'b1) begin
         failures++; $display("FAIL stall_resume pc=%h cnt=%0d run=%b exp pc=18 cnt=12 run=1", pc_o, instr_count_o, running_o);
      end
   endtask

   task automatic test_halt();
      go(jmp(32'h7C), 1'b0);
      go(HALT, 1'b0);
      checks++; if (halted_o !== 1'b1 || running_o !== 1'b0 || pc_o !== 32'h7C || instr_count_o !== 32'd14) begin
         failures++; $display("FAIL halt halt=%b run=%b pc=%h cnt=%0d exp 1 0 7c 14", halted_o, running_o, pc_o, instr_count_o);
      end
      start_i = 1'b1; instr_i = jmp(32'h100);
      repeat (3) tick();
      start_i = 1'b0; stall_i = 1'b1;
      tick();
      stall_i = 1'b0;
      checks++; if (halted_o !== 1'b1 || pc_o !== 32'h7C || instr_count_o !== 32'd14) begin
         failures++; $display("FAIL halt_absorb halt=%b pc=%h cnt=%0d exp 1 7c 14", halted_o, pc_o, instr_count_o);
      end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checks++; if (halted_o !== 1'b0 || running_o !== 1'b0 || pc_o !== 32'h0 || instr_count_o !== 32'd0) begin
         failures++; $display("FAIL halt_reset halt=%b run=%b pc=%h cnt=%0d exp 0 0 0 0", halted_o, running_o, pc_o, instr_count_o);
      end
   endtask

   task automatic test_wrap();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      go(BEQ_M2, 1'b1);
      checks++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
         failures++; $display("FAIL wrap_branch pc=%h pc4=%h exp pc=fffffffc pc4=0", pc_o, pc_plus4_o);
      end
      go(NOP, 1'b0);
      checks++; if (pc_o !== 32'h0 || instr_count_o !== 32'd2) begin
         failures++; $display("FAIL wrap_seq pc=%h cnt=%0d exp pc=0 cnt=2", pc_o, instr_count_o);
      end
   endtask

   task automatic test_reset_mid_run();
      go(NOP, 1'b0);
      stall_i = 1'b1;
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0; stall_i = 1'b0;
      checks++; if (pc_o !== 32'h0 || instr_count_o !== 32'd0 || running_o !== 1'b0) begin
         failures++; $display("FAIL reset_mid_run pc=%h cnt=%0d run=%b exp 0 0 0", pc_o, instr_count_o, running_o);
      end
      go(NOP, 1'b0);
      go(jmp(32'h40), 1'b0);
      checks++; if (pc_o !== 32'h0 || instr_count_o !== 32'd0) begin
         failures++; $display("FAIL idle_hold pc=%h cnt=%0d exp 0 0", pc_o, instr_count_o);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall();
      test_halt();
      test_wrap();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
